// File: rtl/sha_block_fifo.sv
// Multi-entry SHA-2 message-block FIFO with valid/ready on both sides, occupancy count and sync flush.
// Define SHA_BLOCK_FIFO_BYPASS_EN for a zero-latency combinational in->out path when empty.
module sha_block_fifo #(
    parameter int unsigned WIDTH = 288,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clear,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         block_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         block_out,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    // Memory is only popped when it actually holds a block; a bypassed block never touches it.
    assign pop      = !empty && out_ready;

`ifdef SHA_BLOCK_FIFO_BYPASS_EN
    logic bypass;

    assign bypass    = empty && !clear;
    assign out_valid = bypass ? in_valid : !empty;
    assign push      = in_valid && in_ready && !(bypass && out_ready);

    always_comb begin
        block_out = '0;
        if (bypass) begin
            if (in_valid) block_out = block_in;
        end else if (!empty) begin
            block_out = mem[rd_ptr];
        end
    end
`else
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;

    always_comb begin
        block_out = '0;
        if (!empty) block_out = mem[rd_ptr];
    end
`endif

    // Storage, pointers and occupancy; clear overrides any transfer in the same cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= block_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count_q <= count_q + CW'(1);
            else if (pop && !push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_sha_block_fifo.sv
// Directed self-checking bench for sha_block_fifo (DEPTH=4, WIDTH=288).
// Bypass expectations follow SHA_BLOCK_FIFO_BYPASS_EN.
module tb_sha_block_fifo;
    localparam int unsigned TW = 288;
    localparam int unsigned TD = 4;

    logic          CLK;
    logic          RST;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] block_in;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] block_out;
    logic [2:0]    count;

    int n_cmp;
    int n_err;

    sha_block_fifo #(.WIDTH(TW), .DEPTH(TD)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .block_in  (block_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .block_out (block_out),
        .count     (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [TW-1:0] obs, input logic [TW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_state(input string tag, input int cnt, input logic ov, input logic ir);
        check_eq({tag, ".count"},     TW'(count),     TW'(cnt));
        check_eq({tag, ".out_valid"}, TW'(out_valid), TW'(ov));
        check_eq({tag, ".in_ready"},  TW'(in_ready),  TW'(ir));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        RST       = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b1;
        block_in  = '1;
        out_ready = 1'b0;

        // Reset held with a pending all-ones offer: nothing may be stored.
        tick();
        tick();
        check_state("rst", 0, 1'b0, 1'b1);
        check_eq("rst.block_out", block_out, '0);
        in_valid = 1'b0;
        RST      = 1'b1;
        tick();
        check_state("rst_rel", 0, 1'b0, 1'b1);

        // Fill to full with out_ready low.
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            block_in = TW'(i);
            #1;
            check_eq($sformatf("fill%0d.in_ready", i), TW'(in_ready), TW'(1));
            tick();
        end
        check_state("full", 4, 1'b1, 1'b0);
        check_eq("full.block_out", block_out, TW'(1));
        block_in = TW'(5);
        tick();
        check_eq("refuse5.count", TW'(count), TW'(4));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            check_eq($sformatf("drain%0d.block_out", i), block_out, TW'(i));
            tick();
        end
        out_ready = 1'b0;
        check_state("drained", 0, 1'b0, 1'b1);
        check_eq("drained.block_out", block_out, '0);

        // Two deep, then ten simultaneous push+pop cycles.
        in_valid = 1'b1;
        block_in = TW'(32'h10);
        tick();
        block_in = TW'(32'h11);
        tick();
        check_eq("pre_sim.count", TW'(count), TW'(2));
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            block_in = TW'(32'h12 + k);
            #1;
            check_eq($sformatf("sim%0d.block_out", k), block_out, TW'(32'h10 + k));
            tick();
            check_eq($sformatf("sim%0d.count", k), TW'(count), TW'(2));
        end
        in_valid = 1'b0;
        check_eq("sim_drain0", block_out, TW'(32'h1A));
        tick();
        check_eq("sim_drain1", block_out, TW'(32'h1B));
        tick();
        out_ready = 1'b0;
        check_state("sim_done", 0, 1'b0, 1'b1);

        // Full with both sides active: pop only, then the push lands.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            block_in = TW'(32'h20 + i);
            tick();
        end
        block_in  = TW'(32'h24);
        out_ready = 1'b1;
        #1;
        check_eq("fullpop.in_ready", TW'(in_ready), TW'(0));
        check_eq("fullpop.block_out", block_out, TW'(32'h20));
        tick();
        check_eq("fullpop.count", TW'(count), TW'(3));
        check_eq("fullpop.next", block_out, TW'(32'h21));
        check_eq("fullpop.in_ready2", TW'(in_ready), TW'(1));
        tick();
        check_eq("pushpop.count", TW'(count), TW'(3));
        check_eq("pushpop.block_out", block_out, TW'(32'h22));

        // Clear beats a simultaneous push and pop.
        block_in = TW'(32'h99);
        clear    = 1'b1;
        tick();
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_state("clear", 0, 1'b0, 1'b1);
        check_eq("clear.block_out", block_out, '0);
        in_valid = 1'b1;
        block_in = TW'(32'hA5);
        tick();
        in_valid = 1'b0;
        #1;
        check_state("post_clear", 1, 1'b1, 1'b1);
        check_eq("post_clear.block_out", block_out, TW'(32'hA5));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("post_clear.drained", TW'(count), TW'(0));

        // Empty with a consumer waiting.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        block_in  = TW'(32'h5A);
        #1;
`ifdef SHA_BLOCK_FIFO_BYPASS_EN
        check_eq("byp.out_valid", TW'(out_valid), TW'(1));
        check_eq("byp.block_out", block_out, TW'(32'h5A));
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("byp.count", TW'(count), TW'(0));
        check_eq("byp.after", block_out, '0);
`else
        check_eq("nobyp.out_valid", TW'(out_valid), TW'(0));
        check_eq("nobyp.block_out", block_out, '0);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("nobyp.count", TW'(count), TW'(1));
        check_eq("nobyp.block_out1", block_out, TW'(32'h5A));
        tick();
        check_eq("nobyp.count2", TW'(count), TW'(0));
`endif
        out_ready = 1'b0;

        // Asynchronous reset mid-stream discards stored blocks.
        in_valid = 1'b1;
        block_in = TW'(32'h77);
        tick();
        tick();
        in_valid = 1'b0;
        check_eq("pre_arst.count", TW'(count), TW'(2));
        #2;
        RST = 1'b0;
        #1;
        check_state("arst", 0, 1'b0, 1'b1);
        check_eq("arst.block_out", block_out, '0);
        tick();
        RST = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
